// File: rtl/seat_pkg.sv
// Shared encodings for the seat reservation controller and its per-seat slots.
package seat_pkg;

    typedef enum logic [1:0] {
        SEAT_FREE = 2'd0,
        SEAT_AWAY = 2'd1,
        SEAT_OCC  = 2'd2
    } seat_state_e;

    typedef enum logic [1:0] {
        OP_RELEASE = 2'd0,
        OP_AWAY    = 2'd1,
        OP_OCCUPY  = 2'd2,
        OP_ILLEGAL = 2'd3
    } req_op_e;

    typedef enum logic [2:0] {
        RESP_OK    = 3'd0,
        RESP_RANGE = 3'd1,
        RESP_BUSY  = 3'd2,
        RESP_MULTI = 3'd3,
        RESP_OWNER = 3'd4,
        RESP_STATE = 3'd5
    } resp_code_e;

    localparam logic [1:0] CFG_WE_BAN   = 2'd1;
    localparam logic [1:0] CFG_WE_LIMIT = 2'd2;

    localparam int unsigned BAN_ONE_SEAT   = 0;
    localparam int unsigned BAN_OWNER_ONLY = 1;

endpackage

// File: rtl/seat_slot.sv
// One seat: state, owner and away timer, with tick-driven auto-release.
// A commit on the same cycle as a tick always wins and suppresses expiry.
module seat_slot
    import seat_pkg::*;
#(
    parameter int unsigned ID_W   = 32,
    parameter int unsigned TIME_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_tick,
    input  logic [TIME_W-1:0] i_limit,
    input  logic              i_commit,
    input  seat_state_e       i_commit_state,
    input  logic [ID_W-1:0]   i_commit_owner,
    output seat_state_e       o_state,
    output seat_state_e       o_state_nxt,
    output logic [ID_W-1:0]   o_owner,
    output logic              o_expire
);

    seat_state_e       r_state, w_state_nxt;
    logic [ID_W-1:0]   r_owner, w_owner_nxt;
    logic [TIME_W-1:0] r_timer, w_timer_nxt;
    logic [TIME_W:0]   w_sum;
    logic              w_age, w_expire, r_expire;

    always_comb begin
        w_sum       = {1'b0, r_timer} + (TIME_W+1)'(1);
        w_age       = i_tick && (r_state == SEAT_AWAY) && !i_commit;
        w_expire    = w_age && (w_sum >= {1'b0, i_limit});
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_timer_nxt = r_timer;
        if (i_commit) begin
            w_state_nxt = i_commit_state;
            w_owner_nxt = i_commit_owner;
            w_timer_nxt = '0;
        end else if (w_expire) begin
            w_state_nxt = SEAT_FREE;
            w_owner_nxt = '0;
            w_timer_nxt = '0;
        end else if (w_age) begin
            w_timer_nxt = w_sum[TIME_W] ? '1 : w_sum[TIME_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SEAT_FREE;
            r_owner  <= '0;
            r_timer  <= '0;
            r_expire <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_timer  <= w_timer_nxt;
            r_expire <= w_expire;
        end
    end

    assign o_state     = r_state;
    assign o_state_nxt = w_state_nxt;
    assign o_owner     = r_owner;
    assign o_expire    = r_expire;

endmodule

// File: rtl/seat_table_ctrl.sv
// Seat reservation controller: serialises requests, scans all seats for
// multi-seat ownership, then commits one seat update per request.
module seat_table_ctrl
    import seat_pkg::*;
#(
    parameter int unsigned N_SEATS   = 32,
    parameter int unsigned ID_W      = 32,
    parameter int unsigned TIME_W    = 11,
    parameter int unsigned LIMIT_RST = 5,
    parameter int unsigned SEAT_W    = $clog2(N_SEATS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ID_W-1:0]              req_id,
    input  logic [SEAT_W-1:0]            req_seat,
    input  logic [1:0]                   req_op,
    output logic                         resp_valid,
    output logic [2:0]                   resp_code,
    input  logic [1:0]                   cfg_we,
    input  logic [1:0]                   cfg_ban,
    input  logic [TIME_W-1:0]            cfg_limit,
    output logic [2*N_SEATS-1:0]         seat_state,
    output logic [$clog2(N_SEATS+1)-1:0] occ_count,
    output logic [N_SEATS-1:0]           expire_mask
);

    localparam int unsigned OCC_W = $clog2(N_SEATS+1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} fsm_e;

    fsm_e              r_fsm, w_fsm_nxt;
    logic [ID_W-1:0]   r_id;
    logic [SEAT_W-1:0] r_seat, r_idx;
    req_op_e           r_op;
    logic              r_multi, r_short, r_resp_valid;
    resp_code_e        r_short_code, r_resp_code, w_code;
    logic [1:0]        r_ban;
    logic [TIME_W-1:0] r_limit;
    logic [OCC_W-1:0]  r_occ, w_occ_nxt;

    seat_state_e       w_state     [N_SEATS];
    seat_state_e       w_state_nxt [N_SEATS];
    logic [ID_W-1:0]   w_owner     [N_SEATS];
    logic [N_SEATS-1:0] w_expire;

    logic              w_out_of_range, w_short;
    logic              w_wr, w_is_owner;
    seat_state_e       w_wr_state, w_tgt_state;
    logic [ID_W-1:0]   w_wr_owner;

    assign w_out_of_range = {1'b0, req_seat} >= (SEAT_W+1)'(N_SEATS);
    assign w_short        = w_out_of_range || (req_op == OP_ILLEGAL);

    for (genvar g = 0; g < N_SEATS; g++) begin : g_seat
        seat_slot #(
            .ID_W   (ID_W),
            .TIME_W (TIME_W)
        ) u_slot (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_tick         (tick),
            .i_limit        (r_limit),
            .i_commit       (w_wr && (r_seat == SEAT_W'(g))),
            .i_commit_state (w_wr_state),
            .i_commit_owner (w_wr_owner),
            .o_state        (w_state[g]),
            .o_state_nxt    (w_state_nxt[g]),
            .o_owner        (w_owner[g]),
            .o_expire       (w_expire[g])
        );
        assign seat_state[2*g +: 2] = w_state[g];
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:   if (req_valid) w_fsm_nxt = w_short ? S_COMMIT : S_SCAN;
            S_SCAN:   if (r_idx == SEAT_W'(N_SEATS-1)) w_fsm_nxt = S_COMMIT;
            S_COMMIT: w_fsm_nxt = S_IDLE;
            default:  w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    // Owner-only check precedes every op-specific rule.
    always_comb begin
        w_code      = RESP_OK;
        w_wr        = 1'b0;
        w_wr_state  = SEAT_FREE;
        w_wr_owner  = '0;
        w_tgt_state = w_state[r_seat];
        w_is_owner  = (w_owner[r_seat] == r_id);
        if (r_short) begin
            w_code = r_short_code;
        end else if (r_ban[BAN_OWNER_ONLY] && (w_tgt_state != SEAT_FREE) && !w_is_owner) begin
            w_code = RESP_OWNER;
        end else begin
            case (r_op)
                OP_OCCUPY: begin
                    if (w_tgt_state == SEAT_FREE) begin
                        if (r_ban[BAN_ONE_SEAT] && r_multi) begin
                            w_code = RESP_MULTI;
                        end else begin
                            w_wr       = 1'b1;
                            w_wr_state = SEAT_OCC;
                            w_wr_owner = r_id;
                        end
                    end else if (w_is_owner) begin
                        if (w_tgt_state == SEAT_AWAY) begin
                            w_wr       = 1'b1;
                            w_wr_state = SEAT_OCC;
                            w_wr_owner = r_id;
                        end
                    end else begin
                        w_code = RESP_BUSY;
                    end
                end
                OP_AWAY: begin
                    if (w_tgt_state == SEAT_OCC) begin
                        w_wr       = 1'b1;
                        w_wr_state = SEAT_AWAY;
                        w_wr_owner = w_owner[r_seat];
                    end else if (w_tgt_state == SEAT_FREE) begin
                        w_code = RESP_STATE;
                    end
                end
                OP_RELEASE: begin
                    if (w_tgt_state != SEAT_FREE) w_wr = 1'b1;
                    else                          w_code = RESP_STATE;
                end
                default: w_code = RESP_STATE;
            endcase
        end
        w_wr = w_wr && (r_fsm == S_COMMIT);
    end

    always_comb begin
        w_occ_nxt = '0;
        for (int unsigned i = 0; i < N_SEATS; i++) begin
            if (w_state_nxt[i] != SEAT_FREE) w_occ_nxt = w_occ_nxt + OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id         <= '0;
            r_seat       <= '0;
            r_op         <= OP_RELEASE;
            r_idx        <= '0;
            r_multi      <= 1'b0;
            r_short      <= 1'b0;
            r_short_code <= RESP_OK;
            r_resp_valid <= 1'b0;
            r_resp_code  <= RESP_OK;
            r_ban        <= 2'b11;
            r_limit      <= TIME_W'(LIMIT_RST);
            r_occ        <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_occ        <= w_occ_nxt;
            if (cfg_we == CFG_WE_BAN)   r_ban   <= cfg_ban;
            if (cfg_we == CFG_WE_LIMIT) r_limit <= cfg_limit;
            case (r_fsm)
                S_IDLE: begin
                    if (req_valid) begin
                        r_id         <= req_id;
                        r_seat       <= req_seat;
                        r_op         <= req_op_e'(req_op);
                        r_idx        <= '0;
                        r_multi      <= 1'b0;
                        r_short      <= w_short;
                        r_short_code <= w_out_of_range ? RESP_RANGE : RESP_STATE;
                    end
                end
                S_SCAN: begin
                    if ((w_state[r_idx] != SEAT_FREE) && (w_owner[r_idx] == r_id) && (r_idx != r_seat))
                        r_multi <= 1'b1;
                    r_idx <= r_idx + SEAT_W'(1);
                end
                S_COMMIT: begin
                    r_resp_valid <= 1'b1;
                    r_resp_code  <= w_code;
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (r_fsm == S_IDLE);
    assign resp_valid  = r_resp_valid;
    assign resp_code   = r_resp_code;
    assign occ_count   = r_occ;
    assign expire_mask = w_expire;

endmodule
